// File: rtl/snn_pkg.sv
// Shared fixed-point types and saturation helpers for the spiking core.
package snn_pkg;

   localparam int unsigned Q      = 14;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned ACC_W  = 24;

   typedef logic signed [WORD_W-1:0] word_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // Saturate a 32-bit signed value into a Q1.14 word.
   function automatic word_t sat16(input logic signed [31:0] a);
      if (a > 32'sd32767) begin
         return 16'sh7fff;
      end else if (a < -32'sd32768) begin
         return 16'sh8000;
      end else begin
         return word_t'(a[15:0]);
      end
   endfunction

   // Clamp a 32-bit signed value into [lo, hi].
   function automatic word_t clamp(input logic signed [31:0] a, input word_t lo, input word_t hi);
      if (a > 32'(hi)) begin
         return hi;
      end else if (a < 32'(lo)) begin
         return lo;
      end else begin
         return word_t'(a[15:0]);
      end
   endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// Single leaky integrate-and-fire neuron: leak, integrate, saturate, fire, reset.
module snn_lif_neuron
   import snn_pkg::*;
#(
   parameter int ALPHA_Q14 = 15474
) (
   input  logic  clk,
   input  logic  rst,
   input  acc_t  syn_in,
   input  word_t vth,
   output logic  spike
);

   localparam logic signed [31:0] ALPHA = 32'(ALPHA_Q14);

   word_t              v;
   logic signed [31:0] leak;
   logic signed [31:0] v_sum;
   word_t              v_new;
   logic               fire;

   // Leak the membrane, add synaptic input, saturate and compare with threshold.
   always_comb begin
      leak  = (32'(v) * ALPHA) >>> Q;
      v_sum = leak + 32'(syn_in);
      v_new = sat16(v_sum);
      fire  = (v_new >= vth);
   end

   // Membrane and spike registers; a firing neuron restarts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v     <= '0;
         spike <= 1'b0;
      end else begin
         spike <= fire;
         v     <= fire ? '0 : v_new;
      end
   end

endmodule

// File: rtl/snn_core.sv
// Spiking core: N LIF neurons fed by F input channels, with a one-synapse-per-cycle STDP sweep.
module snn_core
   import snn_pkg::*;
#(
   parameter int unsigned F         = 48,
   parameter int unsigned N         = 96,
   parameter int          ALPHA_Q14 = 15474,
   localparam int unsigned AW       = $clog2(F * N)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [F-1:0]  event_vec,
   output logic [N-1:0]  spikes_vec,
   input  logic          stdp_enable,
   input  logic          stdp_enable_pre,
   input  logic          stdp_enable_post,
   input  logic [F-1:0]  stdp_pre_bits,
   input  logic [N-1:0]  stdp_post_bits,
   input  word_t         stdp_eta,
   input  word_t         stdp_lambda_x,
   input  word_t         stdp_lambda_y,
   input  word_t         stdp_b_pre,
   input  word_t         stdp_b_post,
   input  word_t         stdp_wmin,
   input  word_t         stdp_wmax,
   input  logic [7:0]    stdp_eta_shift,
   output logic          stdp_w_we,
   output logic [AW-1:0] stdp_w_addr,
   output word_t         stdp_w_wdata
);

   localparam int unsigned FW = (F > 1) ? $clog2(F) : 1;
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;

   word_t weights_rom [0:F*N-1];
   word_t vth_rom     [0:N-1];

   acc_t               syn_in  [N];
   word_t              x_trace [F];
   word_t              y_trace [N];
   logic [FW-1:0]      f_idx;
   logic [NW-1:0]      n_idx;
   logic [AW-1:0]      sw_addr;
   logic signed [16:0] dw;
   logic signed [33:0] dprod;
   logic signed [31:0] delta;
   logic signed [31:0] w_sum;
   word_t              w_new;

   // Synaptic input per neuron: sum of weights from every active channel.
   always_comb begin
      for (int n = 0; n < int'(N); n++) begin
         syn_in[n] = '0;
         for (int f = 0; f < int'(F); f++) begin
            if (event_vec[f]) begin
               syn_in[n] = syn_in[n] + acc_t'(weights_rom[f*int'(N) + n]);
            end
         end
      end
   end

   for (genvar n = 0; n < N; n++) begin : g_neuron
      snn_lif_neuron #(
         .ALPHA_Q14 (ALPHA_Q14)
      ) u_neuron (
         .clk    (clk),
         .rst    (rstn),
         .syn_in (syn_in[n]),
         .vth    (vth_rom[n]),
         .spike  (spikes_vec[n])
      );
   end

   // Weight update for the synapse under the sweep pointer.
   always_comb begin
      sw_addr = AW'(f_idx) * AW'(N) + AW'(n_idx);
      dw      = '0;
      if (stdp_enable_post && stdp_post_bits[n_idx]) begin
         dw = 17'(x_trace[f_idx]);
      end
      if (stdp_enable_pre && stdp_pre_bits[f_idx]) begin
         dw = dw - 17'(y_trace[n_idx]);
      end
      dprod = 34'(dw) * 34'(stdp_eta);
      delta = 32'((dprod >>> Q) >>> stdp_eta_shift);
      w_sum = 32'(weights_rom[sw_addr]) + delta;
      w_new = clamp(w_sum, stdp_wmin, stdp_wmax);
   end

   // Traces, sweep pointer and the registered write report.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int f = 0; f < int'(F); f++) x_trace[f] <= '0;
         for (int n = 0; n < int'(N); n++) y_trace[n] <= '0;
         f_idx        <= '0;
         n_idx        <= '0;
         stdp_w_we    <= 1'b0;
         stdp_w_addr  <= '0;
         stdp_w_wdata <= '0;
      end else if (stdp_enable) begin
         for (int f = 0; f < int'(F); f++) begin
            x_trace[f] <= sat16(((32'(x_trace[f]) * 32'(stdp_lambda_x)) >>> Q)
                                + (stdp_pre_bits[f] ? 32'(stdp_b_pre) : 32'sd0));
         end
         for (int n = 0; n < int'(N); n++) begin
            y_trace[n] <= sat16(((32'(y_trace[n]) * 32'(stdp_lambda_y)) >>> Q)
                                + (stdp_post_bits[n] ? 32'(stdp_b_post) : 32'sd0));
         end
         if (n_idx == NW'(N - 1)) begin
            n_idx <= '0;
            f_idx <= (f_idx == FW'(F - 1)) ? '0 : f_idx + FW'(1);
         end else begin
            n_idx <= n_idx + NW'(1);
         end
         stdp_w_we    <= 1'b1;
         stdp_w_addr  <= sw_addr;
         stdp_w_wdata <= w_new;
      end else begin
         stdp_w_we    <= 1'b0;
         stdp_w_addr  <= '0;
         stdp_w_wdata <= '0;
      end
   end

   // Weight store write; the array is also loaded hierarchically, so it has no reset.
   always @(posedge clk) begin
      if (!rstn && stdp_enable) begin
         weights_rom[sw_addr] <= w_new;
      end
   end

endmodule

// File: tb/tb_snn_core.sv
// Directed and randomized checks of snn_core against an arithmetic reference model.
module tb_snn_core;

   localparam int F     = 48;
   localparam int N     = 96;
   localparam int AW    = 13;
   localparam int ALPHA = 15474;

   logic                clk;
   logic                rstn;
   logic [F-1:0]        event_vec;
   logic [N-1:0]        spikes_vec;
   logic                stdp_enable, stdp_enable_pre, stdp_enable_post;
   logic [F-1:0]        stdp_pre_bits;
   logic [N-1:0]        stdp_post_bits;
   logic signed [15:0]  stdp_eta, stdp_lambda_x, stdp_lambda_y, stdp_b_pre, stdp_b_post;
   logic signed [15:0]  stdp_wmin, stdp_wmax;
   logic [7:0]          stdp_eta_shift;
   logic                stdp_w_we;
   logic [AW-1:0]       stdp_w_addr;
   logic signed [15:0]  stdp_w_wdata;

   int nerr = 0;
   int nchk = 0;

   // reference model state
   int           w_m   [F*N];
   int           vth_m [N];
   int           v_m   [N];
   int           x_m   [F];
   int           y_m   [N];
   int           ptr;
   logic [N-1:0] spk_m;
   int           we_m, addr_m, wd_m;

   snn_core dut (
      .clk              (clk),
      .rstn             (rstn),
      .event_vec        (event_vec),
      .spikes_vec       (spikes_vec),
      .stdp_enable      (stdp_enable),
      .stdp_enable_pre  (stdp_enable_pre),
      .stdp_enable_post (stdp_enable_post),
      .stdp_pre_bits    (stdp_pre_bits),
      .stdp_post_bits   (stdp_post_bits),
      .stdp_eta         (stdp_eta),
      .stdp_lambda_x    (stdp_lambda_x),
      .stdp_lambda_y    (stdp_lambda_y),
      .stdp_b_pre       (stdp_b_pre),
      .stdp_b_post      (stdp_b_post),
      .stdp_wmin        (stdp_wmin),
      .stdp_wmax        (stdp_wmax),
      .stdp_eta_shift   (stdp_eta_shift),
      .stdp_w_we        (stdp_w_we),
      .stdp_w_addr      (stdp_w_addr),
      .stdp_w_wdata     (stdp_w_wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_int(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // floor(a / 2^s) using plain division
   function automatic longint fdiv(input longint a, input int s);
      longint d;
      if (s > 62) return (a < 0) ? -1 : 0;
      d = longint'(1) << s;
      if (a >= 0) return a / d;
      return -((-a + d - 1) / d);
   endfunction

   function automatic longint lim(input longint a, input longint lo, input longint hi);
      if (a > hi) return hi;
      if (a < lo) return lo;
      return a;
   endfunction

   task automatic model_reset();
      for (int n = 0; n < N; n++) begin v_m[n] = 0; y_m[n] = 0; end
      for (int f = 0; f < F; f++) x_m[f] = 0;
      ptr = 0; spk_m = '0; we_m = 0; addr_m = 0; wd_m = 0;
   endtask

   // one tick of the reference: inference on old weights, then learning
   task automatic model_tick();
      longint sum, nv, dw, delta, s;
      int     fi, ni;
      for (int n = 0; n < N; n++) begin
         sum = 0;
         for (int f = 0; f < F; f++) if (event_vec[f]) sum += w_m[f*N + n];
         nv = lim(fdiv(longint'(v_m[n]) * ALPHA, 14) + sum, -32768, 32767);
         if (nv >= vth_m[n]) begin spk_m[n] = 1'b1; v_m[n] = 0; end
         else begin spk_m[n] = 1'b0; v_m[n] = int'(nv); end
      end
      if (stdp_enable) begin
         fi = ptr / N;
         ni = ptr % N;
         dw = ((stdp_enable_post && stdp_post_bits[ni]) ? longint'(x_m[fi]) : 0)
            - ((stdp_enable_pre && stdp_pre_bits[fi]) ? longint'(y_m[ni]) : 0);
         delta = fdiv(fdiv(dw * longint'(stdp_eta), 14), int'(stdp_eta_shift));
         s = lim(w_m[ptr] + delta, longint'(stdp_wmin), longint'(stdp_wmax));
         w_m[ptr] = int'(s);
         we_m = 1; addr_m = ptr; wd_m = int'(s);
         for (int f = 0; f < F; f++)
            x_m[f] = int'(lim(fdiv(longint'(x_m[f]) * stdp_lambda_x, 14)
                              + (stdp_pre_bits[f] ? longint'(stdp_b_pre) : 0), -32768, 32767));
         for (int n = 0; n < N; n++)
            y_m[n] = int'(lim(fdiv(longint'(y_m[n]) * stdp_lambda_y, 14)
                              + (stdp_post_bits[n] ? longint'(stdp_b_post) : 0), -32768, 32767));
         ptr = (ptr + 1) % (F*N);
      end else begin
         we_m = 0; addr_m = 0; wd_m = 0;
      end
   endtask

   task automatic set_w(input int idx, input int val);
      w_m[idx] = val;
      dut.weights_rom[idx] = 16'(val);
   endtask

   task automatic set_vth(input int n, input int val);
      vth_m[n] = val;
      dut.vth_rom[n] = 16'(val);
   endtask

   task automatic step(input logic [F-1:0] ev);
      event_vec = ev;
      @(posedge clk);
      model_tick();
      #1;
      chk_vec("spikes", spikes_vec, spk_m);
      chk_int("w_we", stdp_w_we, we_m);
      chk_int("w_addr", stdp_w_addr, addr_m);
      chk_int("w_wdata", stdp_w_wdata, wd_m);
   endtask

   initial begin
      int exp_v[3] = '{4096, 7964, 11617};
      rstn = 1'b0;
      event_vec = '0;
      stdp_enable = 0; stdp_enable_pre = 0; stdp_enable_post = 0;
      stdp_pre_bits = '0; stdp_post_bits = '0;
      stdp_eta = 0; stdp_lambda_x = 0; stdp_lambda_y = 0; stdp_b_pre = 0; stdp_b_post = 0;
      stdp_wmin = 0; stdp_wmax = 0; stdp_eta_shift = 0;
      for (int i = 0; i < F*N; i++) set_w(i, 0);
      for (int n = 0; n < N; n++) set_vth(n, 32767);
      model_reset();

      // reset state
      #1 rstn = 1'b1;
      #1;
      chk_vec("rst_spikes", spikes_vec, '0);
      chk_int("rst_we", stdp_w_we, 0);
      chk_int("rst_addr", stdp_w_addr, 0);
      chk_int("rst_wdata", stdp_w_wdata, 0);
      @(negedge clk);
      rstn = 1'b0;

      // single-hit fire on neuron 5
      set_w(5, 16384);
      set_vth(5, 8192);
      step(F'(1));
      chk_vec("single_hit", spikes_vec, N'(1) << 5);
      step('0);
      chk_int("single_hit_clear", spikes_vec[5], 0);

      // leaky integration on neuron 7
      set_w(7, 4096);
      set_vth(7, 12288);
      for (int k = 0; k < 3; k++) begin
         step(F'(1));
         chk_int("leak_v", dut.g_neuron[7].u_neuron.v, exp_v[k]);
         chk_int("leak_nospk", spikes_vec[7], 0);
      end
      step(F'(1));
      chk_int("leak_fire", spikes_vec[7], 1);
      chk_int("leak_vreset", dut.g_neuron[7].u_neuron.v, 0);
      step('0);
      for (int k = 0; k < 3; k++) step(F'(1));

      // asynchronous reset mid-run, then no stale spike
      chk_int("prerst_active", spikes_vec[5], 1);
      rstn = 1'b1;
      #1;
      chk_vec("midrst_spikes", spikes_vec, '0);
      chk_int("midrst_we", stdp_w_we, 0);
      chk_int("midrst_v7", dut.g_neuron[7].u_neuron.v, 0);
      model_reset();
      #1 rstn = 1'b0;
      step(F'(1));
      chk_int("post_rst_v7", dut.g_neuron[7].u_neuron.v, 4096);
      chk_int("no_stale_spike", spikes_vec[7], 0);

      // negative saturation on neuron 3
      for (int f = 0; f < F; f++) set_w(f*N + 3, -32768);
      set_vth(3, 0);
      for (int k = 0; k < 4; k++) begin
         step('1);
         chk_int("negsat_v", dut.g_neuron[3].u_neuron.v, -32768);
         chk_int("negsat_nospk", spikes_vec[3], 0);
      end

      // random inference with learning disabled
      for (int i = 0; i < F*N; i++) set_w(i, int'($urandom_range(5119, 0)) - 2048);
      for (int n = 0; n < N; n++) set_vth(n, int'($urandom_range(20000, 2000)));
      for (int k = 0; k < 200; k++) begin
         stdp_pre_bits    = F'({$urandom(), $urandom()});
         stdp_post_bits   = N'({$urandom(), $urandom(), $urandom()});
         stdp_enable_pre  = 1'($urandom());
         stdp_enable_post = 1'($urandom());
         stdp_eta         = 16'($urandom());
         stdp_b_pre       = 16'($urandom());
         step(F'({$urandom(), $urandom()} & {$urandom(), $urandom()}));
      end
      for (int i = 0; i < F*N; i++) chk_int("w_frozen", dut.weights_rom[i], w_m[i]);

      // random learning
      stdp_enable      = 1;
      stdp_enable_pre  = 1;
      stdp_enable_post = 1;
      stdp_eta         = 16'($urandom_range(16384, 0));
      stdp_lambda_x    = 16'($urandom_range(16000, 8000));
      stdp_lambda_y    = 16'($urandom_range(16000, 8000));
      stdp_b_pre       = 16'($urandom_range(8192, 0));
      stdp_b_post      = 16'($urandom_range(8192, 0));
      stdp_wmin        = 16'(-int'($urandom_range(16384, 4096)));
      stdp_wmax        = 16'($urandom_range(16384, 4096));
      stdp_eta_shift   = 8'($urandom_range(2, 0));
      for (int k = 0; k < 300; k++) begin
         stdp_pre_bits  = F'({$urandom(), $urandom()});
         stdp_post_bits = N'({$urandom(), $urandom(), $urandom()});
         step(F'({$urandom(), $urandom()} & {$urandom(), $urandom()}));
      end
      stdp_enable = 0;
      step('0);
      for (int i = 0; i < F*N; i++) chk_int("w_learned", dut.weights_rom[i], w_m[i]);

      // clamp at wmax with a sweep starting from address 0
      rstn = 1'b1;
      #1;
      model_reset();
      #1 rstn = 1'b0;
      for (int i = 0; i < F*N; i++) set_w(i, 7936);
      stdp_enable = 1; stdp_enable_pre = 1; stdp_enable_post = 1;
      stdp_pre_bits = '1; stdp_post_bits = '1;
      stdp_b_pre = 16384; stdp_b_post = 0; stdp_eta = 16384; stdp_eta_shift = 0;
      stdp_lambda_x = 8192; stdp_lambda_y = 8192;
      stdp_wmin = -32768; stdp_wmax = 8192;
      for (int k = 0; k < 150; k++) begin
         step('0);
         chk_int("clamp_addr", stdp_w_addr, k);
         chk_int("clamp_over_wmax", stdp_w_wdata > 16'sh2000, 0);
      end
      chk_int("clamp_hit", stdp_w_wdata, 8192);
      stdp_enable = 0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/snn_core.md
SNN_CORE -- requirements
Module: snn_core

Interface
REQ-001 Parameters: F=48, input channel count; N=96, neuron count; Q=14, fixed-point fraction bits; ALPHA_Q14=15474, leak factor in Q1.14 (about 0.944).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rstn  in  1  asynchronous, active-high reset (asserted = 1 despite the name).
REQ-004 event_vec  in  F  input spike bits for the current tick; bit f is channel f.
REQ-005 spikes_vec  out  N  registered output spike bits; bit n is neuron n.
REQ-006 stdp_enable, stdp_enable_pre, stdp_enable_post  in  1 each  learning master enable, depression enable, potentiation enable.
REQ-007 stdp_pre_bits  in  F  and  stdp_post_bits  in  N  pre- and post-synaptic spike bits for learning.
REQ-008 stdp_eta, stdp_lambda_x, stdp_lambda_y, stdp_b_pre, stdp_b_post, stdp_wmin, stdp_wmax  in  16 signed each  Q1.14 learning constants.
REQ-009 stdp_eta_shift  in  8  extra right shift applied to the weight delta.
REQ-010 stdp_w_we  out  1; stdp_w_addr  out  AW=$clog2(F*N); stdp_w_wdata  out  16 signed; these report each weight write.
REQ-011 The design SHALL contain unpacked arrays weights_rom[0:F*N-1] (signed 16) and vth_rom[0:N-1] (signed 16) at the top level, with no reset and no initializer, so that testbenches can write them hierarchically.

Function
REQ-012 Weight index: weights_rom[f*N+n] is the synapse from channel f to neuron n, Q1.14.
REQ-013 Membrane potential v[n] SHALL be signed 16-bit Q1.14.
REQ-014 Each cycle, leak SHALL be computed as the 32-bit product v[n]*ALPHA_Q14, arithmetic-shifted right by Q (floor).
REQ-015 Each cycle, the synaptic input SHALL be the sum of weights_rom[f*N+n] over all f with event_vec[f]=1, in a 24-bit signed accumulator.
REQ-016 The new potential SHALL be leak+input, saturated to [-32768, 32767].
REQ-017 Fire rule: if v_new >= vth_rom[n] (signed compare), spikes_vec[n] SHALL be 1 at the next edge and v[n] SHALL be set to 0; otherwise spikes_vec[n]=0 and v[n]=v_new.
REQ-018 Latency: event_vec sampled at edge k SHALL be reflected in spikes_vec after edge k (one cycle). There is no handshake; one tick is processed per cycle.
REQ-019 When stdp_enable=1, each cycle pre-trace x[f] SHALL update as (x*lambda_x)>>>Q, plus b_pre if stdp_pre_bits[f]=1, saturated to 16 bits.
REQ-020 When stdp_enable=1, each cycle post-trace y[n] SHALL update the same way using lambda_y and b_post. When stdp_enable=0, both traces hold.
REQ-021 When stdp_enable=1, a sweep pointer (f,n) SHALL visit one synapse per cycle, n fastest, wrapping from (F-1,N-1) to (0,0).
REQ-022 Sweep delta: dw = (enable_post & post_bits[n] ? x[f] : 0) - (enable_pre & pre_bits[f] ? y[n] : 0); delta = ((dw*eta)>>>Q)>>>eta_shift.
REQ-023 Sweep write: w_new = clamp(w+delta, wmin, wmax); w_new SHALL be written to weights_rom, and stdp_w_we=1, stdp_w_addr=f*N+n, stdp_w_wdata=w_new SHALL be registered one cycle later.
REQ-024 With stdp_enable=0: stdp_w_we=0, stdp_w_addr=0, stdp_w_wdata=0, the sweep pointer holds, and weights_rom is never modified by the core.
REQ-025 A sweep write and an inference read of the same weight in one cycle: inference SHALL use the pre-write value.

Reset
REQ-026 While rstn=1, without a clock edge: v, x, y, sweep pointer, spikes_vec and the stdp_w_* outputs SHALL all be 0.
REQ-027 weights_rom and vth_rom SHALL NOT be affected by reset. Operation SHALL resume on the first edge after deassertion.

Structure
REQ-028 Package snn_pkg SHALL hold Q, the Q1.14 word typedef, and sat16/clamp functions.
REQ-029 One sub-module, snn_lif_neuron, SHALL be instantiated N times and perform the leak, saturation, compare and reset of a single neuron.

Verification
REQ-030 Assert rstn mid-run with no clock edge -> spikes_vec==0 immediately; next event produces no stale spike.
REQ-031 Single-hit fire: w[0*N+5]=0x4000, vth[5]=0x2000, event_vec=1 for one cycle -> spikes_vec==(1<<5) next cycle, then 0 (v[5] reset).
REQ-032 Leaky integration: w[0*N+7]=0x1000, vth[7]=0x3000, event bit0 held -> v=4096, 7964, 11617, 15067; spikes_vec[7] SHALL be 1 only after the 4th event.
REQ-033 Negative saturation: every w[f*N+3]=0x8000 (-2.0), vth[3]=0, all events=1 -> v[3] saturates at -32768, spikes_vec[3] never 1.
REQ-034 STDP off: 200 cycles of random events with stdp_enable=0 -> stdp_w_we stays 0 and weights_rom is unchanged.
REQ-035 STDP clamp: enable, wmax=0x2000, all post and pre bits 1, b_pre=0x4000, eta=0x4000 -> every written wdata <= 0x2000 and addresses increment 0,1,2,...
